// File: rtl/vga_layer_ctrl.sv
// vga_layer_ctrl: frame-synchronous layer mask / background controller for
// the pixel colour mux, with a frame-counted blink phase for the debug layer.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   frame_start, visible      frame pulse, visible-area flag
//   debug/map/wall_en, _rgb   per-layer hit and 6-bit colour
//   cfg_valid/cfg_ready       config handshake (cfg_layers, cfg_bg)
//   active_layers, active_bg  committed mask and background
//   cfg_applied               one-clk pulse after a commit
//   blink_phase               debug blink phase
//   out_rgb                   registered pixel colour (1-cycle latency)
module vga_layer_ctrl #(
  parameter int unsigned BLINK_FRAMES = 16,
  parameter logic [3:0]  RESET_LAYERS = 4'b0111
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       visible,
  input  logic       debug_en,
  input  logic [5:0] debug_rgb,
  input  logic       map_en,
  input  logic [5:0] map_rgb,
  input  logic       wall_en,
  input  logic [5:0] wall_rgb,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_layers,
  input  logic [5:0] cfg_bg,
  output logic [3:0] active_layers,
  output logic [5:0] active_bg,
  output logic       cfg_applied,
  output logic       blink_phase,
  output logic [5:0] out_rgb
);

  localparam int unsigned CNT_W = $clog2(BLINK_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t           state_q, state_d;
  logic             capture, commit;
  logic [3:0]       pend_layers_q, layers_q;
  logic [5:0]       pend_bg_q, bg_q;
  logic             applied_q;
  logic [CNT_W-1:0] cnt_q;
  logic             blink_q;
  logic [5:0]       rgb_q, rgb_d;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    capture   = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          capture = 1'b1;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (frame_start) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_layers_q <= '0;
      pend_bg_q     <= '0;
      layers_q      <= RESET_LAYERS;
      bg_q          <= '0;
      applied_q     <= 1'b0;
    end else begin
      applied_q <= commit;
      if (capture) begin
        pend_layers_q <= cfg_layers;
        pend_bg_q     <= cfg_bg;
      end
      if (commit) begin
        layers_q <= pend_layers_q;
        bg_q     <= pend_bg_q;
      end
    end
  end

  // Blink counter advances on every frame, independent of config traffic.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else if (frame_start) begin
      if (cnt_q == CNT_MAX) begin
        cnt_q   <= '0;
        blink_q <= ~blink_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Uses the pre-edge mask, so the frame_start pixel still sees the old config.
  always_comb begin
    rgb_d = bg_q;
    if (!visible)
      rgb_d = '0;
    else if (debug_en && layers_q[2] && (!layers_q[3] || blink_q))
      rgb_d = debug_rgb;
    else if (map_en && layers_q[1])
      rgb_d = map_rgb;
    else if (wall_en && layers_q[0])
      rgb_d = wall_rgb;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) rgb_q <= '0;
    else          rgb_q <= rgb_d;
  end

  assign active_layers = layers_q;
  assign active_bg     = bg_q;
  assign cfg_applied   = applied_q;
  assign blink_phase   = blink_q;
  assign out_rgb       = rgb_q;

endmodule

// File: doc/vga_layer_ctrl.md
Name: vga_layer_ctrl

Overview:
- Frame-synchronous controller for the pixel colour mux stage.
- Takes per-layer enables/colours (debug, map, wall) plus background, applies a runtime layer mask and background colour, and outputs a registered 6-bit RGB pixel.
- Config arrives on a valid/ready handshake, is held pending, and is committed only at the next frame start, so no frame mixes two configs.
- Also generates a frame-counted blink phase for the debug overlay.

Parameters:
- BLINK_FRAMES, 16, frames per blink half-period; legal range 2..256. Counter width is $clog2(BLINK_FRAMES).
- RESET_LAYERS, 4'b0111, active layer mask after reset: wall, map, debug on; blink off.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous reset, active-low
- frame_start  input  1  one-clk pulse at start of each frame
- visible  input  1  current pixel is in the visible area
- debug_en  input  1  debug layer hit
- debug_rgb  input  6  debug colour
- map_en  input  1  map layer hit
- map_rgb  input  6  map colour
- wall_en  input  1  wall layer hit
- wall_rgb  input  6  wall colour
- cfg_valid  input  1  config request
- cfg_ready  output  1  controller can accept config
- cfg_layers  input  4  mask: [0] wall, [1] map, [2] debug, [3] debug blink enable
- cfg_bg  input  6  background colour
- active_layers  output  4  currently committed mask
- active_bg  output  6  currently committed background
- cfg_applied  output  1  one-clk pulse, cycle after commit
- blink_phase  output  1  current debug blink phase
- out_rgb  output  6  registered pixel colour

Behaviour:
- Reset (reset_n low at a clk edge) sets:
  - active_layers=RESET_LAYERS, active_bg=0, out_rgb=0
  - cfg_applied=0, blink_phase=0, blink counter=0
  - FSM=IDLE, pending registers cleared
  - Reset mid-PENDING discards the pending config.
- FSM:
  - IDLE: cfg_ready=1. When cfg_valid&&cfg_ready, capture cfg_layers/cfg_bg into pending and go to PENDING.
  - PENDING: cfg_ready=0; cfg_valid ignored; the requester holds it.
  - PENDING with frame_start: copy pending into active_layers/active_bg (visible from the next cycle), pulse cfg_applied on the next cycle, return to IDLE.
- Simultaneous events:
  - Handshake in IDLE on the same cycle as frame_start: capture only. Commit happens at the following frame_start.
  - In the commit cycle, cfg_ready is still 0, so back-to-back accept is not possible. The earliest re-accept is the cycle after the commit.
- Blink:
  - On each frame_start the counter increments.
  - At BLINK_FRAMES-1 the counter wraps to 0 and blink_phase toggles.
  - The counter runs regardless of cfg state and is not reset by commits.
- Pixel path, 1-cycle latency; inputs sampled at edge N give out_rgb valid after edge N.
- Priority, first match wins, using committed active values:
  1. !visible -> 0
  2. debug_en && L[2] && (!L[3] || blink_phase) -> debug_rgb
  3. map_en && L[1] -> map_rgb
  4. wall_en && L[0] -> wall_rgb
  5. otherwise -> active_bg
- A disabled layer falls through to lower priority; it does not blank the pixel.
- Mask commit and pixel path share the same edge. The pixel sampled on the frame_start cycle uses the OLD mask; the next pixel uses the new one.
- No arithmetic beyond the counter compare. All outputs are registered except cfg_ready, which is decoded from the FSM state.

Test Plan:
- Reset, then visible=1 with no layer enables -> out_rgb=0 one cycle after; active_layers=0111; cfg_ready=1.
- After reset, debug_en=1 (debug_rgb=6'h3F), map_en=1 (map_rgb=6'h0C), visible=1 -> out_rgb=3F. Then visible=0 -> out_rgb=00 next cycle.
- Send cfg_layers=0001, cfg_bg=6'h15 mid-frame:
  - cfg_ready drops the next cycle; active_layers stays 0111 until frame_start.
  - After frame_start: active_layers=0001, cfg_applied pulses once, cfg_ready=1.
  - With map_en only, out_rgb=15 (map masked, falls to background).
- Handshake on the same cycle as frame_start -> no commit that frame. Commit occurs at the next frame_start, one cfg_applied pulse.
- Layers=0111|1000 (blink on), BLINK_FRAMES=4:
  - blink_phase toggles on every 4th frame_start.
  - With debug_en=1 and map_en=1, out_rgb alternates between map_rgb (phase 0) and debug_rgb (phase 1) across 4-frame periods.
- Assert reset_n low while in PENDING, then release -> active_layers=0111, no cfg_applied at the next frame_start, cfg_ready=1.
